// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder (truncating, denormals flushed) with valid/ready on both sides.
// Optional macro FP_ADD_SUB_EN adds the sub port; sub=1 computes a-b.
module fp_add_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
`ifdef FP_ADD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic                   busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // ALIGN | unpack, classify specials, swap, align smaller mantissa
    // ADD   | add or subtract aligned mantissas
    // NORM  | carry shift or leading-zero normalise
    // PACK  | truncate, range check, assemble result
    // DONE  | result presented until out_ready
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int LW = $clog2(MW + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_b, r_out, r_spec_val;
    logic            r_special, r_sign, r_eff_sub, r_nzero;
    logic [MW-1:0]   r_ml, r_ms, r_nman;
    logic [MW:0]     r_sum;
    logic [EW-1:0]   r_exp, r_nexp;

    logic [W-1:0]    w_b_in, w_l, w_s, w_spec_val, w_packed;
    logic [EXP_W-1:0] w_ea, w_eb, w_shamt;
    logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic            w_swap, w_l_zero, w_s_zero, w_special, w_sticky;
    logic [W-2:0]    w_mag_a, w_mag_b;
    logic [MW-1:0]   w_ml, w_ms, w_ms_al, w_nshift;
    logic [LW-1:0]   w_lzc;
    logic            w_unused;

`ifdef FP_ADD_SUB_EN
    assign w_b_in = {b[W-1] ^ sub, b[W-2:0]};
`else
    assign w_b_in = b;
`endif

    // Operand classification; exp==0 operands count as zero regardless of fraction.
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_a_nan  = (&w_ea) && (|r_a[MAN_W-1:0]);
    assign w_b_nan  = (&w_eb) && (|r_b[MAN_W-1:0]);
    assign w_a_inf  = (&w_ea) && !(|r_a[MAN_W-1:0]);
    assign w_b_inf  = (&w_eb) && !(|r_b[MAN_W-1:0]);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_mag_a  = w_a_zero ? '0 : r_a[W-2:0];
    assign w_mag_b  = w_b_zero ? '0 : r_b[W-2:0];
    assign w_swap   = (w_mag_b > w_mag_a);
    assign w_l      = w_swap ? r_b : r_a;
    assign w_s      = w_swap ? r_a : r_b;
    assign w_l_zero = w_swap ? w_b_zero : w_a_zero;
    assign w_s_zero = w_swap ? w_a_zero : w_b_zero;
    assign w_ml     = w_l_zero ? '0 : {1'b1, w_l[MAN_W-1:0], 3'b000};
    assign w_ms     = w_s_zero ? '0 : {1'b1, w_s[MAN_W-1:0], 3'b000};
    assign w_shamt  = w_l[W-2:MAN_W] - w_s[W-2:MAN_W];

    always_comb begin
        w_special  = 1'b0;
        w_spec_val = '0;
        if (w_a_nan || w_b_nan) begin
            w_special  = 1'b1;
            w_spec_val = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_special  = 1'b1;
            w_spec_val = (r_a[W-1] == r_b[W-1]) ? r_a : QNAN;
        end else if (w_a_inf) begin
            w_special  = 1'b1;
            w_spec_val = r_a;
        end else if (w_b_inf) begin
            w_special  = 1'b1;
            w_spec_val = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_special  = 1'b1;
            w_spec_val = {r_a[W-1] & r_b[W-1], {(W-1){1'b0}}};
        end
    end

    // Alignment shifter; bits shifted out collapse into the sticky position.
    always_comb begin
        w_ms_al  = '0;
        w_sticky = 1'b0;
        if (32'(w_shamt) >= 32'(MW - 1)) begin
            w_ms_al = {{(MW-1){1'b0}}, |w_ms};
        end else begin
            w_ms_al = w_ms >> w_shamt;
            for (int i = 0; i < MW; i++) begin
                if (($unsigned(i) < 32'(w_shamt)) && w_ms[i])
                    w_sticky = 1'b1;
            end
            w_ms_al[0] = w_ms_al[0] | w_sticky;
        end
    end

    always_comb begin
        w_lzc = LW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (r_sum[i])
                w_lzc = LW'(MW - 1 - i);
        end
    end

    assign w_nshift = r_sum[MW-1:0] << w_lzc;

    always_comb begin
        w_packed = '0;
        if (r_special)
            w_packed = r_spec_val;
        else if (r_nzero)
            w_packed = '0;
        else if (r_nexp[EW-1] || (r_nexp == '0))
            w_packed = {r_sign, {(W-1){1'b0}}};
        else if (r_nexp[EW-2:0] >= {1'b0, {EXP_W{1'b1}}})
            w_packed = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            w_packed = {r_sign, r_nexp[EXP_W-1:0], r_nman[MW-2:3]};
    end

    // Hidden bit and guard/round/sticky are dropped by truncation.
    assign w_unused = ^{r_nman[MW-1], r_nman[2:0]};

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_ALIGN;
            S_ALIGN: w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_PACK;
            S_PACK:  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign out = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_out      <= '0;
            r_spec_val <= '0;
            r_special  <= 1'b0;
            r_sign     <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_nzero    <= 1'b0;
            r_ml       <= '0;
            r_ms       <= '0;
            r_nman     <= '0;
            r_sum      <= '0;
            r_exp      <= '0;
            r_nexp     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= w_b_in;
                    end
                end
                S_ALIGN: begin
                    r_special  <= w_special;
                    r_spec_val <= w_spec_val;
                    r_sign     <= w_l[W-1];
                    r_eff_sub  <= w_l[W-1] ^ w_s[W-1];
                    r_exp      <= EW'(w_l[W-2:MAN_W]);
                    r_ml       <= w_ml;
                    r_ms       <= w_ms_al;
                end
                S_ADD: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_ml} - {1'b0, r_ms})
                                       : ({1'b0, r_ml} + {1'b0, r_ms});
                end
                S_NORM: begin
                    r_nzero <= (r_sum == '0);
                    if (r_sum[MW]) begin
                        r_nman <= r_sum[MW:1];
                        r_nexp <= r_exp + EW'(1);
                    end else begin
                        r_nman <= w_nshift;
                        r_nexp <= r_exp - EW'(w_lzc);
                    end
                end
                S_PACK: r_out <= w_packed;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq (EXP_W=8, MAN_W=23) with hand-computed single-precision vectors.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy, sub;
    logic [31:0] a, b, out;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic        prev_ov = 1'b0;
    logic [31:0] exp_pop;
    string       name_pop;
    logic [31:0] sb_val[$];
    string       sb_name[$];

    fp_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef FP_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
        end
    endtask

    // Monitor: samples on the falling edge; a handshake seen here completes at the next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov)
                check("latency_edges", 32'(cyc - acc_cyc), 32'd4);
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (sb_val.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %08h expected no output", out);
                end else begin
                    exp_pop  = sb_val.pop_front();
                    name_pop = sb_name.pop_front();
                    check(name_pop, out, exp_pop);
                end
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [31:0] texp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept_timeout: in_ready=0 expected 1", name);
            return;
        end
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        sb_val.push_back(texp);
        sb_name.push_back(name);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_val.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_val.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout: pending=%0d expected 0", name, sb_val.size());
        end
    endtask

    localparam int NV = 14;
    logic [31:0] va [NV] = '{32'h41700000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF,
                             32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h00000000,
                             32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3FC00000,
                             32'h00C00000, 32'h80C00000};
    logic [31:0] vb [NV] = '{32'h41A00000, 32'hBF800000, 32'h80000000, 32'h7F7FFFFF,
                             32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                             32'h3F800000, 32'h30800000, 32'hB0800000, 32'hBFA00000,
                             32'h80800000, 32'h00800000};
    logic [31:0] ve [NV] = '{32'h420C0000, 32'h00000000, 32'h80000000, 32'h7F800000,
                             32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000,
                             32'h3F800000, 32'h3F800000, 32'h3F7FFFFF, 32'h3E800000,
                             32'h00000000, 32'h80000000};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            issue($sformatf("vec%0d", i), va[i], vb[i], 1'b0, ve[i]);
        drain("vectors");

`ifdef FP_ADD_SUB_EN
        issue("sub_20_minus_15", 32'h41A00000, 32'h41700000, 1'b1, 32'h40A00000);
`else
        issue("sub_ignored", 32'h41A00000, 32'h41700000, 1'b1, 32'h420C0000);
`endif
        drain("sub");

        // Backpressure: result must be held while out_ready is low.
        out_ready = 1'b0;
        issue("bp_2_plus_1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_out", out, 32'h40400000);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // Abort an operation in NORM with a reset pulse.
        issue("aborted", 32'h41700000, 32'h41A00000, 1'b0, 32'h420C0000);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_val.delete();
        sb_name.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out", out, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        issue("after_abort_1_plus_1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        drain("final");
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
